parallax_ctrl: RTL and testbench
================================

PARALLAX_CTRL -- requirements
Module: parallax_ctrl

Interface
REQ-001 Parameter LINE_LEN, default 1280: active pixels per line.
REQ-002 Parameter FRAME_LINES, default 720: lines per frame.
REQ-003 Parameter MAX_CORR, default 128: largest legal correction value.
REQ-004 Parameter RESET_CORR, default 32: correction value applied out of reset.
REQ-005 Clock and reset SHALL be exactly: reset reset_n, asynchronous, active-low; clock clk.
REQ-006 clk  input  1  system clock; all logic is rising-edge.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 cfg_corr  input  8  requested correction value from host.
REQ-009 cfg_valid  input  1  host request is valid.
REQ-010 cfg_ready  output  1  block can accept a request.
REQ-011 frame_start  input  1  single-cycle pulse marking the start of frame vertical blanking.
REQ-012 raw_data_valid / raw_data_sop / raw_data_eop  input  1 each  monitored stream feeding the parallax datapath.
REQ-013 parallax_corr  output  8  registered correction value driven to the datapath.
REQ-014 line_cnt  output  10  completed lines in the current frame.
REQ-015 upd_done  output  1  one-cycle pulse when a new correction value is applied.
REQ-016 err_range / err_len / err_sync  output  1 each  one-cycle error pulses.

Function
REQ-017 Handshake: a request SHALL be accepted on any cycle with cfg_valid=1 and cfg_ready=1.
REQ-018 cfg_ready SHALL be 1 when no request is pending and 0 while one is pending.
REQ-019 An accepted cfg_corr > MAX_CORR SHALL be dropped, SHALL NOT become pending, and SHALL pulse err_range on the next cycle.
REQ-020 An accepted in-range value SHALL be latched as pending.
REQ-021 The FSM SHALL have three states: WAIT_FRAME (reset state), LINE_GAP and IN_LINE.
REQ-022 WAIT_FRAME -> LINE_GAP on frame_start.
REQ-023 LINE_GAP -> IN_LINE on raw_data_valid & raw_data_sop.
REQ-024 IN_LINE -> LINE_GAP on raw_data_valid & raw_data_eop when line_cnt+1 < FRAME_LINES.
REQ-025 IN_LINE -> WAIT_FRAME on raw_data_valid & raw_data_eop when line_cnt+1 = FRAME_LINES.
REQ-026 sop in WAIT_FRAME SHALL be ignored and SHALL pulse err_sync.
REQ-027 Apply rule: a pending value SHALL be loaded into parallax_corr only on a frame_start cycle with state not IN_LINE.
REQ-028 On apply, upd_done SHALL pulse on the following cycle and pending SHALL clear, so cfg_ready=1 one cycle later.
REQ-029 A request accepted on the same cycle as frame_start SHALL NOT apply in that frame; it stays pending until the next frame_start.
REQ-030 parallax_corr SHALL never change during IN_LINE.
REQ-031 frame_start during IN_LINE SHALL pulse err_sync, SHALL NOT apply pending, and SHALL force LINE_GAP with line_cnt=0 and pixel counter=0.
REQ-032 An 11-bit pixel counter SHALL count raw_data_valid cycles from sop to eop inclusive.
REQ-033 The pixel counter SHALL saturate at 2047.
REQ-034 On eop, a count != LINE_LEN SHALL pulse err_len; line_cnt SHALL still increment.
REQ-035 sop while IN_LINE (missing eop) SHALL pulse err_len and restart the pixel count at 1.
REQ-036 eop while in LINE_GAP SHALL pulse err_sync and be otherwise ignored.
REQ-037 line_cnt SHALL clear on frame_start and increment on each eop accepted in IN_LINE.
REQ-038 sop and eop are qualified only with raw_data_valid=1.
REQ-039 A single-cycle line (sop & eop together) SHALL count as one pixel and complete the line.
REQ-040 Error pulses are independent and may assert on the same cycle.

Reset
REQ-041 While reset_n=0: parallax_corr=RESET_CORR, cfg_ready=1, pending cleared, line_cnt=0, pixel counter=0, FSM=WAIT_FRAME, upd_done=0, all err_* = 0.
REQ-042 Reset asserted mid-line SHALL discard any pending request.
REQ-043 After reset release, the first line is accepted only after a frame_start.

Verification
REQ-044 Post-reset: parallax_corr=32, cfg_ready=1; cfg_corr=40 accepted -> cfg_ready=0; frame_start -> parallax_corr=40 and upd_done pulse next cycle, cfg_ready=1 one cycle later.
REQ-045 cfg_corr=200 accepted -> err_range pulse; parallax_corr unchanged; cfg_ready stays 1.
REQ-046 720 lines of 1280 valid pixels after frame_start -> line_cnt reaches 720, no errors, FSM returns to WAIT_FRAME.
REQ-047 Line of 1279 pixels -> err_len at eop; line_cnt still increments.
REQ-048 Pending value 16 plus frame_start mid-line -> err_sync; parallax_corr unchanged; the next frame_start in LINE_GAP applies 16.
REQ-049 cfg accepted on the same cycle as frame_start -> not applied; applied at the next frame_start.

Source files
------------

// File: rtl/parallax_ctrl_if.sv
// Host configuration, stream-monitor and status signals of the parallax correction controller.
interface parallax_ctrl_if;
  logic [7:0] cfg_corr;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       frame_start;
  logic       raw_data_valid;
  logic       raw_data_sop;
  logic       raw_data_eop;
  logic [7:0] parallax_corr;
  logic [9:0] line_cnt;
  logic       upd_done;
  logic       err_range;
  logic       err_len;
  logic       err_sync;

  modport master (
    output cfg_corr, cfg_valid, frame_start, raw_data_valid, raw_data_sop, raw_data_eop,
    input  cfg_ready, parallax_corr, line_cnt, upd_done, err_range, err_len, err_sync
  );

  modport slave (
    input  cfg_corr, cfg_valid, frame_start, raw_data_valid, raw_data_sop, raw_data_eop,
    output cfg_ready, parallax_corr, line_cnt, upd_done, err_range, err_len, err_sync
  );
endinterface

// File: rtl/parallax_ctrl.sv
// Parallax correction controller: holds a host correction request until a safe frame boundary,
// tracks line/pixel framing of the monitored stream and flags range, length and sync errors.
module parallax_ctrl #(
  parameter int unsigned LINE_LEN    = 1280,
  parameter int unsigned FRAME_LINES = 720,
  parameter int unsigned MAX_CORR    = 128,
  parameter int unsigned RESET_CORR  = 32
) (
  input logic            clk,
  input logic            reset_n,
  parallax_ctrl_if.slave bus_if
);

  localparam logic [8:0]  MaxCorrW     = 9'(MAX_CORR);
  localparam logic [7:0]  ResetCorrW   = 8'(RESET_CORR);
  localparam logic [10:0] LineLenW     = 11'(LINE_LEN);
  localparam logic [10:0] FrameLinesW  = 11'(FRAME_LINES);

  typedef enum logic [1:0] {StWaitFrame, StLineGap, StInLine} state_e;

  state_e      r_state,     w_state_d;
  logic        r_pending,   w_pending_d;
  logic [7:0]  r_pend_val,  w_pend_val_d;
  logic [7:0]  r_corr,      w_corr_d;
  logic [9:0]  r_line_cnt,  w_line_cnt_d;
  logic [10:0] r_pix_cnt,   w_pix_cnt_d;
  logic        r_upd_done,  w_upd_done_d;
  logic        r_err_range, w_err_range_d;
  logic        r_err_len,   w_err_len_d;
  logic        r_err_sync,  w_err_sync_d;

  logic        w_accept;
  logic        w_sop;
  logic        w_eop;
  logic        w_line_done;
  logic [10:0] w_pix_inc;
  logic [10:0] w_pix_new;
  logic [10:0] w_line_inc;

  assign w_accept   = bus_if.cfg_valid & ~r_pending;
  assign w_sop      = bus_if.raw_data_valid & bus_if.raw_data_sop;
  assign w_eop      = bus_if.raw_data_valid & bus_if.raw_data_eop;
  assign w_pix_inc  = (r_pix_cnt == 11'h7FF) ? r_pix_cnt : r_pix_cnt + 11'd1;
  assign w_pix_new  = w_sop ? 11'd1 : w_pix_inc;
  assign w_line_inc = {1'b0, r_line_cnt} + 11'd1;

  // A line completes on eop in a line, or on a single-cycle sop+eop line from the gap.
  assign w_line_done = ~bus_if.frame_start & w_eop &
                       ((r_state == StInLine) | ((r_state == StLineGap) & w_sop));

  always_comb begin
    w_state_d     = r_state;
    w_pending_d   = r_pending;
    w_pend_val_d  = r_pend_val;
    w_corr_d      = r_corr;
    w_line_cnt_d  = r_line_cnt;
    w_pix_cnt_d   = r_pix_cnt;
    w_upd_done_d  = 1'b0;
    w_err_range_d = 1'b0;
    w_err_len_d   = 1'b0;
    w_err_sync_d  = 1'b0;

    if (w_accept) begin
      if ({1'b0, bus_if.cfg_corr} > MaxCorrW) begin
        w_err_range_d = 1'b1;
      end else begin
        w_pending_d  = 1'b1;
        w_pend_val_d = bus_if.cfg_corr;
      end
    end

    if (bus_if.frame_start) begin
      w_state_d    = StLineGap;
      w_line_cnt_d = '0;
      w_pix_cnt_d  = '0;
      // Only r_pending is consulted, so a request taken this same cycle waits a frame.
      if (r_state == StInLine) begin
        w_err_sync_d = 1'b1;
      end else if (r_pending) begin
        w_corr_d     = r_pend_val;
        w_pending_d  = 1'b0;
        w_upd_done_d = 1'b1;
      end
    end else begin
      unique case (r_state)
        StWaitFrame: begin
          if (w_sop) w_err_sync_d = 1'b1;
        end
        StLineGap: begin
          if (w_sop) begin
            w_state_d   = StInLine;
            w_pix_cnt_d = 11'd1;
          end else if (w_eop) begin
            w_err_sync_d = 1'b1;
          end
        end
        StInLine: begin
          if (bus_if.raw_data_valid) begin
            w_pix_cnt_d = w_pix_new;
            if (w_sop) w_err_len_d = 1'b1;
          end
        end
        default: w_state_d = StWaitFrame;
      endcase

      if (w_line_done) begin
        w_pix_cnt_d  = '0;
        w_line_cnt_d = w_line_inc[9:0];
        if (w_pix_new != LineLenW) w_err_len_d = 1'b1;
        w_state_d = (w_line_inc >= FrameLinesW) ? StWaitFrame : StLineGap;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StWaitFrame;
      r_pending   <= 1'b0;
      r_pend_val  <= '0;
      r_corr      <= ResetCorrW;
      r_line_cnt  <= '0;
      r_pix_cnt   <= '0;
      r_upd_done  <= 1'b0;
      r_err_range <= 1'b0;
      r_err_len   <= 1'b0;
      r_err_sync  <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_pending   <= w_pending_d;
      r_pend_val  <= w_pend_val_d;
      r_corr      <= w_corr_d;
      r_line_cnt  <= w_line_cnt_d;
      r_pix_cnt   <= w_pix_cnt_d;
      r_upd_done  <= w_upd_done_d;
      r_err_range <= w_err_range_d;
      r_err_len   <= w_err_len_d;
      r_err_sync  <= w_err_sync_d;
    end
  end

  assign bus_if.cfg_ready     = ~r_pending;
  assign bus_if.parallax_corr = r_corr;
  assign bus_if.line_cnt      = r_line_cnt;
  assign bus_if.upd_done      = r_upd_done;
  assign bus_if.err_range     = r_err_range;
  assign bus_if.err_len       = r_err_len;
  assign bus_if.err_sync      = r_err_sync;

endmodule

// File: tb/tb_parallax_ctrl.sv
// Directed bench for parallax_ctrl; frame geometry is shrunk so a full frame stays short.
module tb_parallax_ctrl;
  localparam int LL = 8;
  localparam int FL = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   n_range = 0;
  int   n_len = 0;
  int   n_sync = 0;

  parallax_ctrl_if bus ();

  parallax_ctrl #(
    .LINE_LEN(LL), .FRAME_LINES(FL), .MAX_CORR(128), .RESET_CORR(32)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus_if(bus)
  );

  initial forever #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.err_range === 1'b1) n_range++;
    if (bus.err_len === 1'b1)   n_len++;
    if (bus.err_sync === 1'b1)  n_sync++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [7:0] v);
    bus.cfg_corr = v; bus.cfg_valid = 1'b1;
    step();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic pulse_fs();
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
  endtask

  task automatic pix(input logic sop, input logic eop);
    bus.raw_data_valid = 1'b1; bus.raw_data_sop = sop; bus.raw_data_eop = eop;
    step();
    bus.raw_data_valid = 1'b0; bus.raw_data_sop = 1'b0; bus.raw_data_eop = 1'b0;
  endtask

  task automatic line(input int n);
    for (int p = 0; p < n; p++) pix(p == 0, p == n - 1);
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if (bus.parallax_corr !== 8'd32) begin errors++;
      $display("FAIL reset_corr got %0d want 32", bus.parallax_corr); end
    checks++; if (bus.cfg_ready !== 1'b1) begin errors++;
      $display("FAIL reset_ready got %b want 1", bus.cfg_ready); end
    checks++; if (bus.line_cnt !== 10'd0 || bus.upd_done !== 1'b0) begin errors++;
      $display("FAIL reset_cnt line_cnt %0d upd %b want 0 0", bus.line_cnt, bus.upd_done); end
    checks++; if ({bus.err_range, bus.err_len, bus.err_sync} !== 3'b000) begin errors++;
      $display("FAIL reset_err got %b want 000", {bus.err_range, bus.err_len, bus.err_sync}); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_apply();
    send_cfg(8'd40);
    checks++; if (bus.cfg_ready !== 1'b0 || bus.parallax_corr !== 8'd32) begin errors++;
      $display("FAIL apply_pend ready %b corr %0d want 0 32", bus.cfg_ready, bus.parallax_corr);
    end
    pulse_fs();
    checks++; if (bus.parallax_corr !== 8'd40 || bus.upd_done !== 1'b1) begin errors++;
      $display("FAIL apply_load corr %0d upd %b want 40 1", bus.parallax_corr, bus.upd_done); end
    checks++; if (bus.cfg_ready !== 1'b1) begin errors++;
      $display("FAIL apply_ready got %b want 1", bus.cfg_ready); end
    step();
    checks++; if (bus.upd_done !== 1'b0) begin errors++;
      $display("FAIL apply_pulse upd %b want 0", bus.upd_done); end
  endtask

  task automatic test_range();
    send_cfg(8'd200);
    checks++; if (bus.err_range !== 1'b1 || bus.cfg_ready !== 1'b1) begin errors++;
      $display("FAIL range_200 err %b ready %b want 1 1", bus.err_range, bus.cfg_ready); end
    checks++; if (bus.parallax_corr !== 8'd40) begin errors++;
      $display("FAIL range_corr got %0d want 40", bus.parallax_corr); end
    send_cfg(8'd128);
    checks++; if (bus.err_range !== 1'b0 || bus.cfg_ready !== 1'b0) begin errors++;
      $display("FAIL range_128 err %b ready %b want 0 0", bus.err_range, bus.cfg_ready); end
    pulse_fs();
    checks++; if (bus.parallax_corr !== 8'd128 || bus.upd_done !== 1'b1) begin errors++;
      $display("FAIL range_apply corr %0d upd %b want 128 1", bus.parallax_corr, bus.upd_done);
    end
    send_cfg(8'd129);
    checks++; if (bus.err_range !== 1'b1 || bus.cfg_ready !== 1'b1) begin errors++;
      $display("FAIL range_129 err %b ready %b want 1 1", bus.err_range, bus.cfg_ready); end
    step();
  endtask

  task automatic test_frame();
    int b_len, b_sync;
    pulse_fs();
    b_len = n_len; b_sync = n_sync;
    for (int l = 0; l < FL; l++) begin
      line(LL);
      step();
    end
    checks++; if (bus.line_cnt !== 10'(FL)) begin errors++;
      $display("FAIL frame_lines got %0d want %0d", bus.line_cnt, FL); end
    checks++; if (n_len != b_len || n_sync != b_sync) begin errors++;
      $display("FAIL frame_errs len %0d sync %0d want 0 0", n_len - b_len, n_sync - b_sync); end
    pix(1'b1, 1'b0);
    checks++; if (bus.err_sync !== 1'b1 || bus.line_cnt !== 10'(FL)) begin errors++;
      $display("FAIL frame_wait sync %b lines %0d want 1 %0d", bus.err_sync, bus.line_cnt, FL);
    end
    step();
  endtask

  task automatic test_len();
    pulse_fs();
    line(LL - 1);
    checks++; if (bus.err_len !== 1'b1 || bus.line_cnt !== 10'd1) begin errors++;
      $display("FAIL len_short err %b lines %0d want 1 1", bus.err_len, bus.line_cnt); end
    pix(1'b1, 1'b1);
    checks++; if (bus.err_len !== 1'b1 || bus.line_cnt !== 10'd2) begin errors++;
      $display("FAIL len_single err %b lines %0d want 1 2", bus.err_len, bus.line_cnt); end
    pix(1'b0, 1'b1);
    checks++; if (bus.err_sync !== 1'b1 || bus.line_cnt !== 10'd2) begin errors++;
      $display("FAIL len_gap_eop sync %b lines %0d want 1 2", bus.err_sync, bus.line_cnt); end
    pix(1'b1, 1'b0); pix(1'b0, 1'b0); pix(1'b0, 1'b0);
    pix(1'b1, 1'b0);
    checks++; if (bus.err_len !== 1'b1) begin errors++;
      $display("FAIL len_resop err %b want 1", bus.err_len); end
    for (int p = 0; p < LL - 1; p++) pix(1'b0, p == LL - 2);
    checks++; if (bus.err_len !== 1'b0 || bus.line_cnt !== 10'd3) begin errors++;
      $display("FAIL len_restart err %b lines %0d want 0 3", bus.err_len, bus.line_cnt); end
    step();
  endtask

  task automatic test_midline();
    int b_len;
    send_cfg(8'd16);
    pix(1'b1, 1'b0); pix(1'b0, 1'b0); pix(1'b0, 1'b0);
    pulse_fs();
    checks++; if (bus.err_sync !== 1'b1 || bus.parallax_corr !== 8'd128) begin errors++;
      $display("FAIL mid_fs sync %b corr %0d want 1 128", bus.err_sync, bus.parallax_corr); end
    checks++; if (bus.upd_done !== 1'b0 || bus.line_cnt !== 10'd0 || bus.cfg_ready !== 1'b0)
    begin errors++;
      $display("FAIL mid_state upd %b lines %0d ready %b want 0 0 0",
               bus.upd_done, bus.line_cnt, bus.cfg_ready);
    end
    pulse_fs();
    checks++; if (bus.parallax_corr !== 8'd16 || bus.upd_done !== 1'b1) begin errors++;
      $display("FAIL mid_apply corr %0d upd %b want 16 1", bus.parallax_corr, bus.upd_done); end
    b_len = n_len;
    line(LL);
    step();
    checks++; if (n_len != b_len || bus.line_cnt !== 10'd1) begin errors++;
      $display("FAIL mid_line len_errs %0d lines %0d want 0 1", n_len - b_len, bus.line_cnt); end
  endtask

  task automatic test_same_cycle();
    bus.cfg_corr = 8'd50; bus.cfg_valid = 1'b1; bus.frame_start = 1'b1;
    step();
    bus.cfg_valid = 1'b0; bus.frame_start = 1'b0;
    checks++; if (bus.parallax_corr !== 8'd16 || bus.upd_done !== 1'b0 || bus.cfg_ready !== 1'b0)
    begin errors++;
      $display("FAIL same_hold corr %0d upd %b ready %b want 16 0 0",
               bus.parallax_corr, bus.upd_done, bus.cfg_ready);
    end
    step();
    pulse_fs();
    checks++; if (bus.parallax_corr !== 8'd50 || bus.upd_done !== 1'b1) begin errors++;
      $display("FAIL same_next corr %0d upd %b want 50 1", bus.parallax_corr, bus.upd_done); end
    step();
  endtask

  task automatic test_reset_midline();
    send_cfg(8'd77);
    pix(1'b1, 1'b0); pix(1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.parallax_corr !== 8'd32 || bus.cfg_ready !== 1'b1 || bus.line_cnt !== 10'd0)
    begin errors++;
      $display("FAIL rst_async corr %0d ready %b lines %0d want 32 1 0",
               bus.parallax_corr, bus.cfg_ready, bus.line_cnt);
    end
    step();
    reset_n = 1'b1;
    step();
    pix(1'b1, 1'b0);
    checks++; if (bus.err_sync !== 1'b1) begin errors++;
      $display("FAIL rst_nosof sync %b want 1", bus.err_sync); end
    pulse_fs();
    checks++; if (bus.upd_done !== 1'b0 || bus.parallax_corr !== 8'd32) begin errors++;
      $display("FAIL rst_discard upd %b corr %0d want 0 32", bus.upd_done, bus.parallax_corr); end
    pix(1'b1, 1'b0);
    checks++; if (bus.err_sync !== 1'b0) begin errors++;
      $display("FAIL rst_first_line sync %b want 0", bus.err_sync); end
  endtask

  initial begin
    bus.cfg_corr = '0; bus.cfg_valid = 1'b0; bus.frame_start = 1'b0;
    bus.raw_data_valid = 1'b0; bus.raw_data_sop = 1'b0; bus.raw_data_eop = 1'b0;
    test_reset();
    test_apply();
    test_range();
    test_frame();
    test_len();
    test_midline();
    test_same_cycle();
    test_reset_midline();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
